vertex_rmw_update: RTL and testbench

Read-modify-write update engine that sits directly upstream of the vertex-property URAM (one registered read port with 1-cycle latency, one write port, shared enable, old-data-on-collision read). It accepts a stream of (address, value) updates and folds each value into the stored word with a fixed reduce operator, sustaining one update per cycle. It also provides a full-memory clear sweep. Back-to-back updates to the same address are hazard-free through single-entry write forwarding.

---
 rtl/vertex_rmw_update.sv | 163 ++++++++++++++++
 tb/tb_vertex_rmw_update.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vertex_rmw_update.sv
// ============================================================================
//  Module      : vertex_rmw_update
//  Description : Read-modify-write update engine in front of a 1-cycle-latency
//                vertex-property URAM. Folds (addr, val) updates into stored
//                words at one update per cycle, forwards the last write to
//                cover the read/write hazard, and provides a clear sweep.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vertex_rmw_update #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 10,
    parameter int                OP       = 0,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              upd_valid,
    output logic              upd_ready,
    input  logic [ADDR_W-1:0] upd_addr,
    input  logic [DATA_W-1:0] upd_val,
    input  logic              clear_start,
    output logic              busy,
    output logic              clear_done,
    output logic [31:0]       upd_count,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_raddr,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic              ram_wen,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                clear_done_q, clear_done_d;
    logic [31:0]         upd_count_q, upd_count_d;

    // Stage-1 pipeline register: update whose read is in flight
    logic                p1_valid_q, p1_valid_d;
    logic [ADDR_W-1:0]   p1_addr_q, p1_addr_d;
    logic [DATA_W-1:0]   p1_val_q, p1_val_d;

    // Forwarding register: the write not yet visible to last cycle's read
    logic                w_valid_q, w_valid_d;
    logic [ADDR_W-1:0]   w_addr_q, w_addr_d;
    logic [DATA_W-1:0]   w_data_q, w_data_d;

    logic                accept;
    logic                clearing;
    logic [DATA_W-1:0]   old_word;
    logic [DATA_W-1:0]   new_word;

    // Next-state, datapath and URAM port control
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        clear_done_d = 1'b0;

        clearing  = (state_q == S_CLEAR);
        upd_ready = ~rst & ~clear_start & (state_q == S_IDLE);
        accept    = upd_valid & upd_ready;

        case (state_q)
            S_IDLE: begin
                if (clear_start) begin
                    state_d = p1_valid_q ? S_WAIT : S_CLEAR;
                end
            end
            S_WAIT: begin
                if (!p1_valid_q) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (cnt_q == {ADDR_W{1'b1}}) begin
                    state_d      = S_IDLE;
                    cnt_d        = '0;
                    clear_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d      = (state_d != S_IDLE);
        upd_count_d = upd_count_q + 32'(accept);

        p1_valid_d = accept;
        p1_addr_d  = upd_addr;
        p1_val_d   = upd_val;

        // Last cycle's write has not reached the word the URAM just returned
        old_word = (w_valid_q && (w_addr_q == p1_addr_q)) ? w_data_q : ram_dout;
        if (OP == 1) begin
            new_word = (old_word < p1_val_q) ? old_word : p1_val_q;
        end else begin
            new_word = old_word + p1_val_q;
        end

        ram_raddr = upd_addr;
        ram_waddr = p1_addr_q;
        ram_din   = new_word;
        ram_wen   = 1'b0;
        if (clearing) begin
            ram_wen   = ~rst;
            ram_waddr = cnt_q;
            ram_din   = INIT_VAL;
        end else if (p1_valid_q) begin
            ram_wen = ~rst;
        end
        ram_en = ~rst & (accept | p1_valid_q | clearing);

        w_valid_d = ram_wen;
        w_addr_d  = ram_waddr;
        w_data_d  = ram_din;
    end

    // All engine state; reset drops any in-flight write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            clear_done_q <= 1'b0;
            upd_count_q  <= '0;
            p1_valid_q   <= 1'b0;
            p1_addr_q    <= '0;
            p1_val_q     <= '0;
            w_valid_q    <= 1'b0;
            w_addr_q     <= '0;
            w_data_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            clear_done_q <= clear_done_d;
            upd_count_q  <= upd_count_d;
            p1_valid_q   <= p1_valid_d;
            p1_addr_q    <= p1_addr_d;
            p1_val_q     <= p1_val_d;
            w_valid_q    <= w_valid_d;
            w_addr_q     <= w_addr_d;
            w_data_q     <= w_data_d;
        end
    end

    assign busy       = busy_q;
    assign clear_done = clear_done_q;
    assign upd_count  = upd_count_q;

endmodule

`default_nettype wire

// File: tb/tb_vertex_rmw_update.sv
// ============================================================================
//  Module      : tb_vertex_rmw_update
//  Description : Self-checking bench for vertex_rmw_update. Two instances
//                (add and min reduce) share stimulus; each has its own URAM
//                model and a scoreboard of expected writes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vertex_rmw_update;

    localparam int          DW    = 32;
    localparam int          AW    = 4;
    localparam int          DEPTH = 16;
    localparam logic [31:0] INIT  = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          upd_valid   = 1'b0;
    logic          clear_start = 1'b0;
    logic [AW-1:0] upd_addr    = '0;
    logic [DW-1:0] upd_val     = '0;

    logic          rdy0, busy0, done0, en0, wen0;
    logic [31:0]   cnt0;
    logic [AW-1:0] ra0, wa0;
    logic [DW-1:0] din0, dout0;
    logic          rdy1, busy1, done1, en1, wen1;
    logic [31:0]   cnt1;
    logic [AW-1:0] ra1, wa1;
    logic [DW-1:0] din1, dout1;

    vertex_rmw_update #(.DATA_W(DW), .ADDR_W(AW), .OP(0), .INIT_VAL(INIT)) dut0 (
        .clk(clk), .rst(rst), .upd_valid(upd_valid), .upd_ready(rdy0),
        .upd_addr(upd_addr), .upd_val(upd_val), .clear_start(clear_start),
        .busy(busy0), .clear_done(done0), .upd_count(cnt0), .ram_en(en0),
        .ram_raddr(ra0), .ram_waddr(wa0), .ram_wen(wen0), .ram_din(din0),
        .ram_dout(dout0)
    );

    vertex_rmw_update #(.DATA_W(DW), .ADDR_W(AW), .OP(1), .INIT_VAL(INIT)) dut1 (
        .clk(clk), .rst(rst), .upd_valid(upd_valid), .upd_ready(rdy1),
        .upd_addr(upd_addr), .upd_val(upd_val), .clear_start(clear_start),
        .busy(busy1), .clear_done(done1), .upd_count(cnt1), .ram_en(en1),
        .ram_raddr(ra1), .ram_waddr(wa1), .ram_wen(wen1), .ram_din(din1),
        .ram_dout(dout1)
    );

    // URAM models: registered read, old data on read/write collision
    logic [DW-1:0] mem0 [DEPTH];
    logic [DW-1:0] mem1 [DEPTH];
    logic          bd_we   = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [DW-1:0] bd_data = '0;

    always @(posedge clk) begin
        if (bd_we) begin
            mem0[bd_addr] <= bd_data;
            mem1[bd_addr] <= bd_data;
        end
        if (en0) begin
            if (wen0) mem0[wa0] <= din0;
            dout0 <= mem0[ra0];
        end
        if (en1) begin
            if (wen1) mem1[wa1] <= din1;
            dout1 <= mem1[ra1];
        end
    end

    // Reference contents and expected write streams
    logic [DW-1:0] ref0 [DEPTH];
    logic [DW-1:0] ref1 [DEPTH];
    wr_t           q0 [$];
    wr_t           q1 [$];
    int            exp_count = 0;
    int            checks    = 0;
    int            passes    = 0;

    // Scoreboard: every URAM write must match the next expected write
    always @(negedge clk) begin
        if (!rst) begin
            if (wen0) begin
                checks++;
                if (q0.size() == 0) begin
                    $display("FAIL wr0_unexpected: got addr=%0d data=%h, required no write", wa0, din0);
                end else begin
                    wr_t e;
                    e = q0.pop_front();
                    if (wa0 !== e.a || din0 !== e.d)
                        $display("FAIL wr0: got addr=%0d data=%h, required addr=%0d data=%h", wa0, din0, e.a, e.d);
                    else passes++;
                end
            end
            if (wen1) begin
                checks++;
                if (q1.size() == 0) begin
                    $display("FAIL wr1_unexpected: got addr=%0d data=%h, required no write", wa1, din1);
                end else begin
                    wr_t e;
                    e = q1.pop_front();
                    if (wa1 !== e.a || din1 !== e.d)
                        $display("FAIL wr1: got addr=%0d data=%h, required addr=%0d data=%h", wa1, din1, e.a, e.d);
                    else passes++;
                end
            end
        end
    end

    task automatic bd_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(posedge clk); #1;
        bd_we = 1'b0;
        ref0[a] = d;
        ref1[a] = d;
    endtask

    task automatic push_update(input logic [AW-1:0] a, input logic [DW-1:0] v);
        ref0[a] = ref0[a] + v;
        ref1[a] = (v < ref1[a]) ? v : ref1[a];
        q0.push_back({a, ref0[a]});
        q1.push_back({a, ref1[a]});
        exp_count++;
    endtask

    task automatic push_clear();
        for (int i = 0; i < DEPTH; i++) begin
            q0.push_back({AW'(i), INIT});
            q1.push_back({AW'(i), INIT});
        end
    endtask

    // Offer one update for one cycle; engine must be ready (called at posedge+1)
    task automatic offer(input logic [AW-1:0] a, input logic [DW-1:0] v);
        upd_valid = 1'b1; upd_addr = a; upd_val = v;
        #1;
        checks++;
        if (rdy0 !== 1'b1 || rdy1 !== 1'b1)
            $display("FAIL offer_ready: got rdy0=%b rdy1=%b, required 1", rdy0, rdy1);
        else passes++;
        push_update(a, v);
        @(posedge clk); #1;
    endtask

    task automatic idle_cycles(input int n);
        upd_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        upd_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) bd_write(AW'(i), '0);
        @(negedge clk);
        checks++;
        if (en0 !== 1'b0 || wen0 !== 1'b0 || rdy0 !== 1'b0)
            $display("FAIL reset_port: got en=%b wen=%b ready=%b, required 0 0 0", en0, wen0, rdy0);
        else passes++;
        checks++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || cnt0 !== 32'd0)
            $display("FAIL reset_state: got busy=%b done=%b count=%0d, required 0 0 0", busy0, done0, cnt0);
        else passes++;
        checks++;
        if (en1 !== 1'b0 || wen1 !== 1'b0 || rdy1 !== 1'b0 || busy1 !== 1'b0)
            $display("FAIL reset_dut1: got en=%b wen=%b ready=%b busy=%b, required 0", en1, wen1, rdy1, busy1);
        else passes++;
        upd_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        idle_cycles(1);
    endtask

    task automatic test_add_same_addr();
        offer(4'd3, 32'd5);
        offer(4'd3, 32'd7);
        offer(4'd3, 32'd1);
        idle_cycles(3);
        checks++;
        if (mem0[3] !== 32'd13) $display("FAIL add_same_addr: got mem[3]=%0d, required 13", mem0[3]);
        else passes++;
        checks++;
        if (cnt0 !== 32'd3) $display("FAIL add_count: got upd_count=%0d, required 3", cnt0);
        else passes++;
    endtask

    task automatic test_alternating();
        offer(4'd1, 32'd1);
        offer(4'd2, 32'd1);
        offer(4'd1, 32'd1);
        offer(4'd2, 32'd1);
        idle_cycles(3);
        checks++;
        if (mem0[1] !== 32'd2 || mem0[2] !== 32'd2)
            $display("FAIL alternating: got mem[1]=%0d mem[2]=%0d, required 2 2", mem0[1], mem0[2]);
        else passes++;
        checks++;
        if (cnt0 !== exp_count[31:0]) $display("FAIL alt_count: got %0d, required %0d", cnt0, exp_count);
        else passes++;
    endtask

    task automatic test_clear_with_p1();
        int n;
        bit ok;
        offer(4'd5, 32'd3);
        upd_valid = 1'b0;
        clear_start = 1'b1;
        push_clear();
        #1;
        checks++;
        if (rdy0 !== 1'b0) $display("FAIL clear_p1_ready: got %b, required 0", rdy0);
        else passes++;
        @(posedge clk); #1;
        clear_start = 1'b0;
        checks++;
        if (busy0 !== 1'b1 || wen0 !== 1'b0)
            $display("FAIL clear_wait: got busy=%b wen=%b, required 1 0", busy0, wen0);
        else passes++;
        n = 1;
        ok = 1'b1;
        while (done0 !== 1'b1 && n < 100) begin
            if (rdy0 !== 1'b0) ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!ok) $display("FAIL clear_ready_low: got ready=1 during sweep, required 0");
        else passes++;
        checks++;
        if (n !== 18) $display("FAIL clear_p1_latency: got %0d cycles, required 18", n);
        else passes++;
        checks++;
        if (busy0 !== 1'b0) $display("FAIL clear_busy_end: got %b, required 0", busy0);
        else passes++;
        @(posedge clk); #1;
        checks++;
        if (done0 !== 1'b0) $display("FAIL clear_done_pulse: got %b, required 0", done0);
        else passes++;
        ok = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem0[i] !== INIT || mem1[i] !== INIT) ok = 1'b0;
            ref0[i] = INIT;
            ref1[i] = INIT;
        end
        checks++;
        if (!ok) $display("FAIL clear_contents: got a word other than %h, required all %h", INIT, INIT);
        else passes++;
    endtask

    task automatic test_min_and_wrap();
        offer(4'd2, 32'd9);
        offer(4'd2, 32'd4);
        offer(4'd2, 32'd6);
        offer(4'd0, 32'd2);
        idle_cycles(3);
        checks++;
        if (mem1[2] !== 32'd4) $display("FAIL min_back_to_back: got mem[2]=%0d, required 4", mem1[2]);
        else passes++;
        checks++;
        if (mem0[0] !== 32'd1) $display("FAIL add_wrap: got mem[0]=%0d, required 1", mem0[0]);
        else passes++;
    endtask

    task automatic test_reset_mid_clear();
        int  n;
        bit  ok;
        for (int i = 0; i < DEPTH; i++) bd_write(AW'(i), 32'hA500_0000 | 32'(i));
        clear_start = 1'b1;
        push_clear();
        @(posedge clk); #1;
        clear_start = 1'b0;
        n = 0;
        while (!(wen0 === 1'b1 && wa0 === 4'd6) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) $display("FAIL mid_clear_timeout: got no write to addr 6, required one");
        else passes++;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if (en0 !== 1'b0 || wen0 !== 1'b0 || rdy0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0 || cnt0 !== 32'd0)
            $display("FAIL mid_clear_reset: got en=%b wen=%b rdy=%b busy=%b done=%b cnt=%0d, required all 0",
                     en0, wen0, rdy0, busy0, done0, cnt0);
        else passes++;
        q0.delete();
        q1.delete();
        exp_count = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        idle_cycles(2);
        ok = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (mem0[i] !== INIT) ok = 1'b0;
            ref0[i] = INIT;
            ref1[i] = INIT;
        end
        checks++;
        if (!ok) $display("FAIL mid_clear_low: got a word in 0..6 other than %h, required %h", INIT, INIT);
        else passes++;
        ok = 1'b1;
        for (int i = 7; i < DEPTH; i++)
            if (mem0[i] !== (32'hA500_0000 | 32'(i))) ok = 1'b0;
        checks++;
        if (!ok) $display("FAIL mid_clear_high: got a changed word in 7..15, required A500_00xx untouched");
        else passes++;
    endtask

    task automatic test_clear_holds_update();
        int n;
        bit ok;
        clear_start = 1'b1;
        upd_valid = 1'b1; upd_addr = 4'd4; upd_val = 32'd10;
        push_clear();
        #1;
        checks++;
        if (rdy0 !== 1'b0) $display("FAIL hold_ready_start: got %b, required 0", rdy0);
        else passes++;
        @(posedge clk); #1;
        clear_start = 1'b0;
        n = 1;
        ok = 1'b1;
        while (done0 !== 1'b1 && n < 100) begin
            if (rdy0 !== 1'b0) ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!ok || cnt0 !== 32'd0) $display("FAIL hold_no_accept: got ready seen high=%b count=%0d, required 0 0", !ok, cnt0);
        else passes++;
        checks++;
        if (n !== 17) $display("FAIL clear_latency: got %0d cycles, required 17", n);
        else passes++;
        for (int i = 0; i < DEPTH; i++) begin ref0[i] = INIT; ref1[i] = INIT; end
        checks++;
        if (rdy0 !== 1'b1) $display("FAIL hold_accept_ready: got %b, required 1", rdy0);
        else passes++;
        push_update(4'd4, 32'd10);
        @(posedge clk); #1;
        upd_valid = 1'b0;
        checks++;
        if (cnt0 !== 32'd1) $display("FAIL hold_accept_count: got %0d, required 1", cnt0);
        else passes++;
        idle_cycles(3);
        checks++;
        if (mem0[4] !== 32'd9 || mem1[4] !== 32'd10)
            $display("FAIL hold_result: got mem0[4]=%0d mem1[4]=%0d, required 9 10", mem0[4], mem1[4]);
        else passes++;
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_add_same_addr();
        test_alternating();
        test_clear_with_p1();
        test_min_and_wrap();
        test_reset_mid_clear();
        test_clear_holds_update();
        idle_cycles(2);
        checks++;
        if (q0.size() != 0 || q1.size() != 0)
            $display("FAIL missing_writes: got %0d/%0d pending, required 0", q0.size(), q1.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
